// File: rtl/rtc_ts_pkg.sv
// Shared constants, FSM encoding and packing helpers for the RTC timestamp transmitter.
package rtc_ts_pkg;

    localparam int MS_W     = 10;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;
    localparam int DAY_W    = 5;
    localparam int TS_WIDTH = 32;

    localparam int NUM_BYTES = 5;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    localparam int MS_LSB   = 0;
    localparam int SEC_LSB  = 10;
    localparam int MIN_LSB  = 16;
    localparam int HOUR_LSB = 22;
    localparam int DAY_LSB  = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    typedef logic [2:0] byte_idx_t;

    function automatic logic [TS_WIDTH-1:0] pack_ts(
        input logic [MS_W-1:0]   ms,
        input logic [SEC_W-1:0]  sec,
        input logic [MIN_W-1:0]  min,
        input logic [HOUR_W-1:0] hour,
        input logic [DAY_W-1:0]  day
    );
        logic [TS_WIDTH-1:0] word;
        word = {TS_WIDTH{1'b0}};
        word[MS_LSB   +: MS_W]   = ms;
        word[SEC_LSB  +: SEC_W]  = sec;
        word[MIN_LSB  +: MIN_W]  = min;
        word[HOUR_LSB +: HOUR_W] = hour;
        word[DAY_LSB  +: DAY_W]  = day;
        return word;
    endfunction

    // Byte 0 is the sync header; bytes 1..4 walk the word from the MSB down.
    function automatic logic [7:0] frame_byte(
        input logic [TS_WIDTH-1:0] word,
        input byte_idx_t           idx,
        input logic [7:0]          sync
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rtc_timestamp_tx_if.sv
// Capture request, RTC field inputs and serial/status outputs of the timestamp transmitter.
interface rtc_timestamp_tx_if;
    import rtc_ts_pkg::*;

    logic              capture;
    logic [MS_W-1:0]   millisec;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
    logic [DAY_W-1:0]  day;
    logic              tx;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output capture, millisec, sec, min, hour, day,
        input  tx, busy, done, overrun
    );

    modport slave (
        input  capture, millisec, sec, min, hour, day,
        output tx, busy, done, overrun
    );

endinterface

// File: rtl/rtc_ts_byte_tx.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
module rtc_ts_byte_tx
    import rtc_ts_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_byte_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    tx_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
    logic [2:0]       r_bit,   w_bit_nx;
    logic [7:0]       r_shift, w_shift_nx;
    logic             r_tx,    w_tx_nx;
    logic             w_bit_end;

    assign w_bit_end   = (r_cnt == CNT_LAST);
    // Asserted in the last stop-bit cycle so a following byte can load with no idle gap.
    assign o_byte_done = (r_state == ST_STOP) && w_bit_end;
    assign o_tx        = r_tx;

    // Next-state, baud count, shift path and next line level.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = CNT_ZERO;
                if (i_load) begin
                    w_state_nx = ST_START;
                    w_shift_nx = i_byte;
                    w_tx_nx    = 1'b0;
                end else begin
                    w_tx_nx    = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nx = ST_DATA;
                    w_cnt_nx   = CNT_ZERO;
                    w_bit_nx   = 3'd0;
                    w_tx_nx    = r_shift[0];
                end else begin
                    w_cnt_nx   = r_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = CNT_ZERO;
                    if (r_bit == 3'd7) begin
                        w_state_nx = ST_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_tx_nx    = r_shift[1];
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nx = CNT_ZERO;
                    if (i_load) begin
                        w_state_nx = ST_START;
                        w_shift_nx = i_byte;
                        w_tx_nx    = 1'b0;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_tx_nx    = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = CNT_ZERO;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset drops the line high mid-byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_tx    <= w_tx_nx;
        end
    end

endmodule

// File: rtl/rtc_timestamp_tx.sv
// Snapshots the RTC fields on capture and sends sync + 4-byte timestamp frames,
// with a one-deep pending slot for captures that arrive while a frame is on the wire.
module rtc_timestamp_tx
    import rtc_ts_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_timestamp_tx_if.slave    bus
);

    localparam byte_idx_t LAST_IDX = 3'(NUM_BYTES - 1);

    logic [TS_WIDTH-1:0] r_word,       w_word_nx;
    byte_idx_t           r_idx,        w_idx_nx;
    logic                r_active,     w_active_nx;
    logic                r_pend_valid, w_pend_valid_nx;
    logic [TS_WIDTH-1:0] r_pend_word,  w_pend_word_nx;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;
    logic                w_overrun_nx;

    logic [TS_WIDTH-1:0] w_snap;
    logic                w_load;
    logic [7:0]          w_load_byte;
    logic                w_byte_done;
    logic                w_frame_end;
    logic                w_tx;

    assign w_snap      = pack_ts(bus.millisec, bus.sec, bus.min, bus.hour, bus.day);
    assign w_frame_end = w_byte_done && (r_idx == LAST_IDX);

    rtc_ts_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_byte      (w_load_byte),
        .o_tx        (w_tx),
        .o_byte_done (w_byte_done)
    );

    // Frame sequencing: start, byte advance, frame-end reload, pending capture and overrun.
    always_comb begin
        w_load          = 1'b0;
        w_load_byte     = SYNC_BYTE;
        w_word_nx       = r_word;
        w_idx_nx        = r_idx;
        w_active_nx     = r_active;
        w_pend_valid_nx = r_pend_valid;
        w_pend_word_nx  = r_pend_word;
        w_overrun_nx    = 1'b0;
        if (!r_active) begin
            if (bus.capture) begin
                w_load      = 1'b1;
                w_word_nx   = w_snap;
                w_idx_nx    = 3'd0;
                w_active_nx = 1'b1;
            end else begin
                w_load      = 1'b0;
            end
        end else if (w_frame_end) begin
            if (r_pend_valid) begin
                // Reload empties the slot, so a capture on this same edge refills it.
                w_load          = 1'b1;
                w_word_nx       = r_pend_word;
                w_idx_nx        = 3'd0;
                w_pend_valid_nx = bus.capture;
                w_pend_word_nx  = bus.capture ? w_snap : r_pend_word;
            end else if (bus.capture) begin
                w_load    = 1'b1;
                w_word_nx = w_snap;
                w_idx_nx  = 3'd0;
            end else begin
                w_active_nx = 1'b0;
            end
        end else begin
            if (w_byte_done) begin
                w_load      = 1'b1;
                w_idx_nx    = r_idx + 3'd1;
                w_load_byte = frame_byte(r_word, r_idx + 3'd1, SYNC_BYTE);
            end else begin
                w_load      = 1'b0;
            end
            if (bus.capture) begin
                if (!r_pend_valid) begin
                    w_pend_valid_nx = 1'b1;
                    w_pend_word_nx  = w_snap;
                end else begin
                    w_overrun_nx    = 1'b1;
                end
            end else begin
                w_overrun_nx = 1'b0;
            end
        end
    end

    // Sequencing state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word       <= {TS_WIDTH{1'b0}};
            r_idx        <= 3'd0;
            r_active     <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_word  <= {TS_WIDTH{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_word       <= w_word_nx;
            r_idx        <= w_idx_nx;
            r_active     <= w_active_nx;
            r_pend_valid <= w_pend_valid_nx;
            r_pend_word  <= w_pend_word_nx;
            r_busy       <= w_active_nx | w_pend_valid_nx;
            r_done       <= w_frame_end;
            r_overrun    <= w_overrun_nx;
        end
    end

    assign bus.tx      = w_tx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_rtc_timestamp_tx.sv
// Randomized bench: frame-level reference model plus a mid-bit UART receiver on tx.
module tb_rtc_timestamp_tx;

    localparam int         CPB   = 4;
    localparam int         FRAME = 50 * CPB;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         HALF  = CPB / 2 - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_timestamp_tx_if bus ();

    rtc_timestamp_tx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] ref_word(input int d, input int h, input int mi, input int s, input int ms);
        return 32'(d * 134217728 + h * 4194304 + mi * 65536 + s * 1024 + ms);
    endfunction

    // ---------------- reference model (frame scheduler) ----------------
    int          cyc     = 0;
    logic        m_active = 1'b0;
    logic        m_pend   = 1'b0;
    int          m_end    = 0;
    logic [31:0] m_pword  = 32'd0;
    logic        m_done   = 1'b0;
    logic        m_ovr    = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_log[$];
    logic [31:0] snapv;

    assign snapv = ref_word(bus.day, bus.hour, bus.min, bus.sec, bus.millisec);

    task automatic push_frame(input logic [31:0] w);
        exp_q.push_back(SYNC);
        exp_q.push_back(8'((w / 32'd16777216) % 32'd256));
        exp_q.push_back(8'((w / 32'd65536) % 32'd256));
        exp_q.push_back(8'((w / 32'd256) % 32'd256));
        exp_q.push_back(8'(w % 32'd256));
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_pend   <= 1'b0;
            m_done   <= 1'b0;
            m_ovr    <= 1'b0;
            cyc      <= 0;
            exp_q.delete();
        end else begin
            cyc    <= cyc + 1;
            m_done <= 1'b0;
            m_ovr  <= 1'b0;
            if (m_active && cyc == m_end) begin
                m_done <= 1'b1;
                if (m_pend) begin
                    push_frame(m_pword);
                    m_end  <= cyc + FRAME;
                    m_pend <= bus.capture;
                    if (bus.capture) m_pword <= snapv;
                end else if (bus.capture) begin
                    push_frame(snapv);
                    m_end <= cyc + FRAME;
                end else begin
                    m_active <= 1'b0;
                end
            end else if (bus.capture) begin
                if (!m_active) begin
                    push_frame(snapv);
                    m_active <= 1'b1;
                    m_end    <= cyc + FRAME;
                end else if (!m_pend) begin
                    m_pend  <= 1'b1;
                    m_pword <= snapv;
                end else begin
                    m_ovr <= 1'b1;
                end
            end
        end
    end

    // ---------------- status compare and serial receiver ----------------
    logic       rx_act = 1'b0;
    int         rx_n   = 0;
    logic [7:0] rx_sh  = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            rx_act <= 1'b0;
        end else begin
            check_eq("busy",    bus.busy,    m_active | m_pend);
            check_eq("done",    bus.done,    m_done);
            check_eq("overrun", bus.overrun, m_ovr);
            if (!rx_act) begin
                if (bus.tx == 1'b0) begin
                    rx_act <= 1'b1;
                    rx_n   <= 0;
                end
            end else begin
                rx_n <= rx_n + 1;
                if (rx_n + 1 == HALF) begin
                    check_eq("start_bit", bus.tx, 1'b0);
                end else if (rx_n + 1 >= CPB + HALF && rx_n + 1 <= 8 * CPB + HALF
                             && ((rx_n + 1 - HALF) % CPB) == 0) begin
                    rx_sh <= {bus.tx, rx_sh[7:1]};
                end else if (rx_n + 1 == 9 * CPB + HALF) begin
                    check_eq("stop_bit", bus.tx, 1'b1);
                    rx_act <= 1'b0;
                    rx_log.push_back(rx_sh);
                    check_eq("rx_byte_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) check_eq("rx_byte", rx_sh, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic scramble = 1'b0;
    int   t, busy_cnt, done_cnt, ovr_cnt;
    int   done_at[$];

    task automatic set_fields(input int d, input int h, input int mi, input int s, input int ms);
        bus.day = 5'(d); bus.hour = 5'(h); bus.min = 6'(mi); bus.sec = 6'(s); bus.millisec = 10'(ms);
    endtask

    task automatic begin_test();
        t = -1; busy_cnt = 0; done_cnt = 0; ovr_cnt = 0;
        done_at.delete();
        rx_log.delete();
    endtask

    task automatic step(input logic cap);
        @(negedge clk);
        t++;
        if (bus.busy)    busy_cnt++;
        if (bus.done)    begin done_cnt++; done_at.push_back(t); end
        if (bus.overrun) ovr_cnt++;
        bus.capture = cap;
        if (scramble) begin
            bus.day = 5'($urandom); bus.hour = 5'($urandom); bus.min = 6'($urandom);
            bus.sec = 6'($urandom); bus.millisec = 10'($urandom);
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] word);
        logic [7:0] eb;
        for (int i = 0; i < 5; i++) begin
            eb = (i == 0) ? SYNC : word[31 - 8 * (i - 1) -: 8];
            check_eq(tag, (rx_log.size() > i) ? {24'd0, rx_log[i]} : 32'hFFFF_FFFF, {24'd0, eb});
        end
    endtask

    initial begin
        bus.capture = 1'b0;
        set_fields(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("rst_tx",      bus.tx,      1'b1);
        check_eq("rst_busy",    bus.busy,    1'b0);
        check_eq("rst_done",    bus.done,    1'b0);
        check_eq("rst_overrun", bus.overrun, 1'b0);
        #1 reset = 1'b0;

        // Single frame, known fields
        begin_test();
        set_fields(3, 14, 25, 42, 517);
        step(1'b1);
        repeat (210) step(1'b0);
        check_eq("t1_busy_cycles", busy_cnt, FRAME);
        check_eq("t1_done_count",  done_cnt, 1);
        check_eq("t1_done_time",   (done_at.size() > 0) ? done_at[0] : -1, FRAME + 1);
        check_eq("t1_rx_count",    rx_log.size(), 5);
        check_frame("t1_byte", 32'h1B99_AA05);

        // Maximum legal field values
        begin_test();
        set_fields(30, 23, 59, 59, 999);
        step(1'b1);
        repeat (210) step(1'b0);
        check_eq("t2_done_count", done_cnt, 1);
        check_frame("t2_byte", 32'hF5FB_EFE7);

        // Back-to-back frame from a pending capture, fields churning afterwards
        begin_test();
        set_fields(7, 8, 9, 10, 11);
        step(1'b1);
        repeat (49) step(1'b0);
        set_fields(17, 5, 33, 21, 640);
        step(1'b1);
        scramble = 1'b1;
        repeat (420) step(1'b0);
        scramble = 1'b0;
        check_eq("t3_done_count",  done_cnt, 2);
        check_eq("t3_done1_time",  (done_at.size() > 0) ? done_at[0] : -1, FRAME + 1);
        check_eq("t3_done2_time",  (done_at.size() > 1) ? done_at[1] : -1, 2 * FRAME + 1);
        check_eq("t3_busy_cycles", busy_cnt, 2 * FRAME);
        check_eq("t3_rx_count",    rx_log.size(), 10);

        // Two captures while busy: second one dropped with overrun
        begin_test();
        set_fields(1, 1, 1, 1, 1);
        step(1'b1);
        repeat (19) step(1'b0);
        set_fields(2, 2, 2, 2, 2);
        step(1'b1);
        repeat (39) step(1'b0);
        set_fields(4, 4, 4, 4, 4);
        step(1'b1);
        repeat (420) step(1'b0);
        check_eq("t4_overrun_count", ovr_cnt, 1);
        check_eq("t4_done_count",    done_cnt, 2);
        check_eq("t4_rx_count",      rx_log.size(), 10);

        // Asynchronous reset mid-frame, then a clean frame
        begin_test();
        set_fields(9, 9, 9, 9, 9);
        step(1'b1);
        repeat (37) step(1'b0);
        #1 reset = 1'b1;
        #1;
        check_eq("t5_async_tx",   bus.tx,   1'b1);
        check_eq("t5_async_busy", bus.busy, 1'b0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        begin_test();
        set_fields(1, 2, 3, 4, 5);
        step(1'b1);
        repeat (210) step(1'b0);
        check_eq("t5_done_count", done_cnt, 1);
        check_frame("t5_byte", 32'h0883_1005);

        // Random captures with fields changing every cycle
        scramble = 1'b1;
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 59) == 0);
        scramble = 1'b0;
        for (int i = 0; i < 1000 && (m_active || m_pend || rx_act); i++) step(1'b0);
        repeat (4) step(1'b0);
        check_eq("drain_idle",  m_active | m_pend | rx_act, 1'b0);
        check_eq("drain_busy",  bus.busy, 1'b0);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
